philv_trace_ctrl: RTL and testbench
===================================

PHILV_TRACE_CTRL -- requirements
Module: philv_trace_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one probe channel.
REQ-002 SHALL have parameter NUM_CH, default 4: number of probe channels captured per cycle.
REQ-003 SHALL have parameter DEPTH, default 16: trace entries; power of two, at least 2.
REQ-004 SHALL have parameter CNT_W, default 16: width of the cycle counter.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstb, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port start, input, 1: one-cycle run request, honoured only in IDLE.
REQ-008 SHALL have port cycles, input, CNT_W: run length, sampled with start.
REQ-009 SHALL have port mode, input, 1: 0 = STOP_ON_FULL, 1 = WRAP; sampled with start.
REQ-010 SHALL have port probe, input, NUM_CH*DATA_W: core state snapshot; channel 0 in the LSBs.
REQ-011 SHALL have port core_en, output, 1: registered core clock-enable.
REQ-012 SHALL have ports busy (1) and done (1), both outputs: busy = not IDLE; done = one-cycle end-of-run pulse.
REQ-013 SHALL have ports rd_valid (out, 1), rd_ready (in, 1), rd_data (out, NUM_CH*DATA_W) and rd_cycle (out, CNT_W): trace readout.
REQ-014 SHALL have ports count (out, $clog2(DEPTH)+1) and overflow (out, 1): entries held; entries lost or run truncated.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-016 IDLE: start with cycles != 0 SHALL latch cycles and mode, clear buffer, count, overflow and the cycle counter, and enter RUN next cycle.
REQ-017 IDLE: start with cycles == 0 SHALL pulse done the next cycle and stay in IDLE; buffer is not cleared.
REQ-018 core_en SHALL be 1 exactly in RUN; start accepted at edge k gives core_en high from cycle k+1 for exactly cycles cycles (unless truncated).
REQ-019 Each RUN cycle SHALL write probe and the current cycle index (0-based) as one entry.
REQ-020 RUN SHALL go to DRAIN on the edge that writes index cycles-1.
REQ-021 STOP_ON_FULL: a write that fills the buffer (count reaches DEPTH) before index cycles-1 SHALL set overflow and go to DRAIN on that edge.
REQ-022 WRAP: a write with count == DEPTH SHALL overwrite the oldest entry, advance the read pointer, keep count at DEPTH and set overflow.
REQ-023 rd_valid SHALL be 1 only in DRAIN with count != 0; rd_data and rd_cycle show the oldest entry.
REQ-024 A transfer (rd_valid and rd_ready) SHALL pop one entry; rd_data and rd_cycle hold steady while rd_valid is high and rd_ready is low.
REQ-025 DRAIN with count == 0 (after a pop or on entry) SHALL go to IDLE and pulse done for one cycle.
REQ-026 start outside IDLE SHALL be ignored; rd_ready outside DRAIN SHALL be ignored.
REQ-027 Pointers SHALL wrap modulo DEPTH; the cycle counter SHALL NOT wrap within a run (cycles <= 2^CNT_W - 1).

Reset
REQ-028 rstb high at an edge SHALL force IDLE and set core_en, busy, done, rd_valid, count, overflow, the pointers and the cycle counter to 0, including mid-RUN or mid-DRAIN.
REQ-029 rd_data and rd_cycle SHALL be 0 after reset; buffer storage need not be cleared.

Structure
REQ-030 SHALL take the state enum and the MODE_STOP and MODE_WRAP constants from shared package philv_pkg.
REQ-031 Storage, pointers and count SHALL live in sub-module philv_trace_fifo (parameters WIDTH, DEPTH), with overwrite-on-full as an input.

Verification
REQ-032 DATA_W=32, NUM_CH=4, DEPTH=16: start with cycles=5, mode=0, probe = cycle-tagged pattern -> core_en high 5 cycles; 5 entries read with rd_cycle 0..4; done once; overflow=0.
REQ-033 cycles=20, mode=0 -> core_en high 16 cycles; overflow=1; 16 entries read, rd_cycle 0..15.
REQ-034 cycles=20, mode=1 -> core_en high 20 cycles; overflow=1; 16 entries read, rd_cycle 4..19.
REQ-035 cycles=0 -> done pulses the next cycle; core_en never rises; busy stays 0.
REQ-036 rd_ready toggled 1,0,0,1 during DRAIN -> data stable while stalled, no entry lost or duplicated; rstb pulsed mid-RUN at cycle 3 -> next cycle IDLE, core_en=0, count=0.
REQ-037 start asserted during RUN and DRAIN -> ignored; run length and readout unchanged.

Source files
------------

// File: rtl/philv_pkg.sv
// Shared types and constants for the philv trace controller.
package philv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/philv_trace_fifo.sv
// Circular trace buffer; on a full write with overwrite set, the oldest entry is dropped.
module philv_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic                     overwrite,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, pop, do_wr, drop_old;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pop      = rd_en && (count_q != '0);
    do_wr    = wr_en && !clr && (!full || overwrite || pop);
    drop_old = do_wr && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop || drop_old) rd_ptr_d = rd_ptr_q + PW'(1);
      // An overwrite both adds and drops, leaving count unchanged.
      if (do_wr && !drop_old && !pop) count_d = count_q + CW'(1);
      else if (pop && !do_wr) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/philv_trace_ctrl.sv
// Run controller: gates the core for a programmed number of cycles, traces probe
// snapshots into a buffer, then drains the buffer over a valid/ready port.
module philv_trace_ctrl
  import philv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       start,
  input  logic [CNT_W-1:0]           cycles,
  input  logic                       mode,
  input  logic [NUM_CH*DATA_W-1:0]   probe,
  output logic                       core_en,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic [CNT_W-1:0]           rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PRB_W = NUM_CH * DATA_W;
  localparam int unsigned ENT_W = PRB_W + CNT_W;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             core_en_q, core_en_d;
  logic             busy_q, busy_d;

  logic             fifo_clr, fifo_wr, fifo_rd, fifo_ovw;
  logic [CW-1:0]    fifo_count;
  logic [ENT_W-1:0] fifo_head;

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    mode_d   = mode_q;
    cyc_d    = cyc_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    fifo_clr = 1'b0;
    fifo_wr  = 1'b0;
    fifo_rd  = 1'b0;
    fifo_ovw = (mode_q == MODE_WRAP);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cycles != '0) begin
            cycles_d = cycles;
            mode_d   = mode;
            cyc_d    = '0;
            ovf_d    = 1'b0;
            fifo_clr = 1'b1;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        fifo_wr = 1'b1;
        cyc_d   = cyc_q + CNT_W'(1);
        if (mode_q == MODE_WRAP && fifo_count == CW'(DEPTH)) ovf_d = 1'b1;
        // The final index wins over a simultaneous fill: a full-length run is not truncated.
        if (cyc_q == cycles_q - CNT_W'(1)) begin
          state_d = DRAIN;
        end else if (mode_q == MODE_STOP && fifo_count == CW'(DEPTH - 1)) begin
          ovf_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_count == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          fifo_rd = rd_ready;
        end
      end
      default: state_d = IDLE;
    endcase
    core_en_d = (state_d == RUN);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q   <= IDLE;
      cycles_q  <= '0;
      mode_q    <= MODE_STOP;
      cyc_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      core_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      mode_q    <= mode_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      core_en_q <= core_en_d;
      busy_q    <= busy_d;
    end
  end

  philv_trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rstb),
    .clr       (fifo_clr),
    .wr_en     (fifo_wr),
    .overwrite (fifo_ovw),
    .rd_en     (fifo_rd),
    .wr_data   ({cyc_q, probe}),
    .rd_data   (fifo_head),
    .count     (fifo_count)
  );

  // Readout is masked to zero whenever nothing is presented, so it reads 0 after reset.
  assign rd_valid = (state_q == DRAIN) && (fifo_count != '0);
  assign rd_data  = rd_valid ? fifo_head[PRB_W-1:0] : '0;
  assign rd_cycle = rd_valid ? fifo_head[ENT_W-1:PRB_W] : '0;
  assign core_en  = core_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = fifo_count;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_philv_trace_ctrl.sv
// Directed bench for philv_trace_ctrl with DATA_W=32, NUM_CH=4, DEPTH=16, CNT_W=16.
module tb_philv_trace_ctrl;

  logic         clk = 1'b0;
  logic         rstb;
  logic         start;
  logic [15:0]  cycles;
  logic         mode;
  logic [127:0] probe;
  logic         core_en, busy, done, rd_valid, rd_ready, overflow;
  logic [127:0] rd_data;
  logic [15:0]  rd_cycle;
  logic [4:0]   count;

  int n_err = 0;
  int n_chk = 0;
  int n_edge = 0;

  philv_trace_ctrl #(
    .DATA_W (32),
    .NUM_CH (4),
    .DEPTH  (16),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .start    (start),
    .cycles   (cycles),
    .mode     (mode),
    .probe    (probe),
    .core_en  (core_en),
    .busy     (busy),
    .done     (done),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_cycle (rd_cycle),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(int t);
    logic [127:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch*32 +: 32] = {8'(ch), 8'h5A, 16'(t)};
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Probe presented at edge e+1 is pat(e).
  task automatic step();
    @(posedge clk);
    #1;
    n_edge++;
    probe = pat(n_edge);
  endtask

  task automatic run(input int ncyc, input logic md, input bit stall, input bit glitch,
                     input int exp_en, input int exp_n, input int exp_first, input logic exp_ovf);
    int s, en_cnt, done_cnt, got, dk;
    bit seen, prev_stall, finished;
    logic [127:0] prev_data;
    logic [15:0]  prev_cyc;
    logic [3:0]   rdy_pat;
    rdy_pat = 4'b1001;
    en_cnt = 0; done_cnt = 0; got = 0; dk = 0;
    seen = 0; prev_stall = 0; finished = 0;
    prev_data = '0; prev_cyc = '0;
    cycles = 16'(ncyc); mode = md; start = 1'b1;
    step();
    s = n_edge;
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("core_en_after_start", 128'(core_en), 128'(1));
    for (int i = 0; i < 200; i++) begin
      if (core_en) en_cnt++;
      if (done) done_cnt++;
      if (!busy) begin
        finished = 1;
        break;
      end
      if (prev_stall) begin
        chk("stall_valid", 128'(rd_valid), 128'(1));
        chk("stall_data", rd_data, prev_data);
        chk("stall_cycle", 128'(rd_cycle), 128'(prev_cyc));
      end
      rd_ready = stall ? rdy_pat[dk % 4] : 1'b1;
      if (rd_valid) begin
        dk++;
        if (!seen) chk("drain_count", 128'(count), 128'(exp_n));
        seen = 1;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_cycle", 128'(rd_cycle), 128'(exp_first + got));
        chk("rd_data", rd_data, pat(s + exp_first + got));
        got++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_cyc = rd_cycle;
      cycles = 16'(3);
      start = glitch && busy;
      step();
    end
    start = 1'b0;
    rd_ready = 1'b0;
    chk("run_finished", 128'(finished), 128'(1));
    for (int i = 0; i < 2; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("core_en_cycles", 128'(en_cnt), 128'(exp_en));
    chk("entries_read", 128'(got), 128'(exp_n));
    chk("done_pulses", 128'(done_cnt), 128'(1));
    chk("overflow", 128'(overflow), 128'(exp_ovf));
    chk("count_empty", 128'(count), 128'(0));
  endtask

  initial begin
    rstb = 1'b1; start = 1'b0; cycles = '0; mode = 1'b0; rd_ready = 1'b0;
    probe = pat(0);
    step();
    step();
    rstb = 1'b0;
    chk("rst_core_en", 128'(core_en), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_rd_data", rd_data, 128'(0));
    chk("rst_rd_cycle", 128'(rd_cycle), 128'(0));
    step();

    // Short run, wrap-less stop, full-length fill, wrap.
    run(5, 1'b0, 0, 0, 5, 5, 0, 1'b0);
    run(20, 1'b0, 0, 0, 16, 16, 0, 1'b1);
    run(20, 1'b1, 0, 0, 20, 16, 4, 1'b1);
    run(16, 1'b0, 0, 0, 16, 16, 0, 1'b0);
    // Back-pressure and ignored start.
    run(6, 1'b0, 1, 0, 6, 6, 0, 1'b0);
    run(7, 1'b0, 0, 1, 7, 7, 0, 1'b0);

    // Zero-length run.
    cycles = '0; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_busy", 128'(busy), 128'(0));
    chk("zero_core_en", 128'(core_en), 128'(0));
    step();
    chk("zero_done_once", 128'(done), 128'(0));
    chk("zero_core_en2", 128'(core_en), 128'(0));

    // Reset in the middle of a run at cycle 3.
    cycles = 16'(10); mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("mid_count_pre", 128'(count), 128'(3));
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_core_en", 128'(core_en), 128'(0));
    chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    step();
    chk("mid_rst_idle", 128'(busy), 128'(0));

    run(3, 1'b1, 0, 0, 3, 3, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
